rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 16 +
 rtl/rom_arbiter_rom.sv | 50 +++++
 rtl/rom_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
// Optional read statistics are enabled elsewhere with ROM_ARB_STATS_EN.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;

    // Last-granted pointer value that gives requester 0 priority on a tie.
    localparam logic LAST_FAVOUR_0 = 1'b1;

endpackage

// File: rtl/rom_arbiter_rom.sv
// Small constant lookup ROM with a registered output (one-cycle read latency).
// The output register only loads when en is high, so it holds between reads.
module rom_arbiter_rom #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]            word;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        word = 8'h00;
        case (int'(addr))
            0:       word = 8'h80;
            1:       word = 8'hAA;
            2:       word = 8'h55;
            3:       word = 8'h83;
            4:       word = 8'h00;
            5:       word = 8'h99;
            6:       word = 8'h81;
            7:       word = 8'hF0;
            default: word = 8'h00;
        endcase
    end

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = DATA_WIDTH'(word);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter giving two requesters shared access to a registered ROM.
// Defining ROM_ARB_STATS_EN adds saturating per-requester read counters.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]           rd_count0,
    output logic [15:0]           rd_count1
`endif
);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    logic                  busy_q, busy_d;
    logic                  pick;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rvalid_d = '0;
        gnt      = '0;
        pick     = 1'b0;
        case (state_q)
            IDLE: begin
                // A grant is never offered while reset is being applied.
                if (req != '0 && !reset) begin
                    pick    = (req == 2'b11) ? ~last_q : req[1];
                    gnt     = pick ? 2'b10 : 2'b01;
                    owner_d = pick;
                    last_d  = pick;
                    addr_d  = pick ? addr1 : addr0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rvalid_d = owner_q ? 2'b10 : 2'b01;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= LAST_FAVOUR_0;
            addr_q   <= '0;
            rvalid_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
        end
    end

    rom_arbiter_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) rom (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == ISSUE),
        .addr  (addr_q),
        .data  (rdata)
    );

    // A reset landing on the response cycle swallows the rvalid pulse.
    assign rvalid = reset ? '0 : rvalid_q;
    assign busy   = busy_q;

`ifdef ROM_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (rvalid[0] && cnt0_q != 16'hFFFF) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (rvalid[1] && cnt1_q != 16'hFFFF) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign rd_count0 = cnt0_q;
    assign rd_count1 = cnt1_q;
`endif

endmodule
